shift_seq_ctrl: RTL and testbench

Operand-issue and result-capture stage wrapped around the registered 16-bit LSL shifter (latency 1) in the ALU shift path. Accepts shift ops over a valid/ready handshake. Maps LSL, LSR, ASR and ROL onto the left-only shifter using bit reversal and, where needed, a second pass. Captures the result and presents it downstream with valid/ready.

---
 rtl/shift_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Operand-issue / result-capture sequencer around a registered left-only shifter.
// Optional {N,Z,C} result flags are enabled with the SHIFT_SEQ_FLAGS_EN macro.
module shift_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int SHAMT_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_shamt,
  output logic [WIDTH-1:0] sh_inp,
  output logic [WIDTH-1:0] sh_shift,
  input  logic [WIDTH-1:0] sh_out,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_SEQ_FLAGS_EN
  output logic [2:0]       out_flags,
`endif
  output logic [WIDTH-1:0] out_data
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready=1
  // P1    | pass-1 operands held, shifter samples them
  // P1C   | capture pass-1 result, maybe load pass 2
  // P2    | pass-2 operands held, shifter samples them
  // P2C   | OR pass-2 result into accumulator
  // DONE  | result presented until out_ready
  typedef enum logic [2:0] {IDLE, P1, P1C, P2, P2C, DONE} state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  state_t                state, next_state;
  logic [1:0]            op_q;
  logic [WIDTH-1:0]      x_q;
  logic [SHAMT_BITS-1:0] n_q;
  logic [WIDTH-1:0]      acc;
  logic [WIDTH-1:0]      sh_inp_q;
  logic [SHAMT_BITS-1:0] sh_shift_q;

  logic load1, load2, cap1, cap2;
  logic need2;
  logic [WIDTH-1:0] cap1_val, cap2_val, final_res;
  logic [SHAMT_BITS-1:0] neg_n;

  logic unused_shamt;
  assign unused_shamt = ^in_shamt[WIDTH-1:SHAMT_BITS];

  assign need2 = (op_q == OP_ROL) ||
                 ((op_q == OP_ASR) && x_q[WIDTH-1] && (n_q != '0));

  // Right shifts run through the left shifter between two bit reversals.
  assign cap1_val  = ((op_q == OP_LSR) || (op_q == OP_ASR)) ? rev(sh_out) : sh_out;
  assign cap2_val  = (op_q == OP_ROL) ? rev(sh_out) : sh_out;
  assign final_res = cap2 ? (acc | cap2_val) : cap1_val;
  assign neg_n     = '0 - n_q;

  assign sh_inp   = sh_inp_q;
  assign sh_shift = {{(WIDTH-SHAMT_BITS){1'b0}}, sh_shift_q};
  assign out_data = acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load1      = 1'b0;
    load2      = 1'b0;
    cap1       = 1'b0;
    cap2       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load1      = 1'b1;
          next_state = P1;
        end
      end
      P1:  next_state = P1C;
      P1C: begin
        cap1 = 1'b1;
        if (need2) begin
          load2      = 1'b1;
          next_state = P2;
        end else begin
          next_state = DONE;
        end
      end
      P2:  next_state = P2C;
      P2C: begin
        cap2       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OP_LSL;
      x_q        <= '0;
      n_q        <= '0;
      acc        <= '0;
      sh_inp_q   <= '0;
      sh_shift_q <= '0;
    end else begin
      if (load1) begin
        op_q       <= in_op;
        x_q        <= in_data;
        n_q        <= in_shamt[SHAMT_BITS-1:0];
        sh_inp_q   <= ((in_op == OP_LSR) || (in_op == OP_ASR)) ? rev(in_data) : in_data;
        sh_shift_q <= in_shamt[SHAMT_BITS-1:0];
      end
      if (load2) begin
        // ROL wraps the low bits in; ASR fills the vacated top bits with ones.
        sh_inp_q   <= (op_q == OP_ROL) ? rev(x_q) : '1;
        sh_shift_q <= neg_n;
      end
      if (cap1) acc <= cap1_val;
      if (cap2) acc <= acc | cap2_val;
    end
  end

`ifdef SHIFT_SEQ_FLAGS_EN
  logic [2:0]            flags_q;
  logic [WIDTH-1:0]      x_rev;
  logic [SHAMT_BITS-1:0] nm1;
  logic                  carry;

  assign x_rev     = rev(x_q);
  assign nm1       = n_q - 1'b1;
  assign out_flags = flags_q;

  // Carry is the last bit shifted out; x_rev[n-1] is x[WIDTH-n].
  always_comb begin
    carry = 1'b0;
    if (n_q != '0) begin
      case (op_q)
        OP_LSL:         carry = x_rev[nm1];
        OP_LSR, OP_ASR: carry = x_q[nm1];
        default:        carry = final_res[0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 3'b000;
    end else if ((cap1 && !need2) || cap2) begin
      flags_q <= {final_res[WIDTH-1], (final_res == '0), carry};
    end
  end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural shifter and result model.
// Flag checks are compiled in when SHIFT_SEQ_FLAGS_EN is defined.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_data;
  logic [15:0] in_shamt;
  logic [15:0] sh_inp;
  logic [15:0] sh_shift;
  logic [15:0] sh_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef SHIFT_SEQ_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  shift_seq_ctrl #(.WIDTH(16), .SHAMT_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt),
    .sh_inp(sh_inp), .sh_shift(sh_shift), .sh_out(sh_out),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef SHIFT_SEQ_FLAGS_EN
    .out_flags(out_flags),
`endif
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered LSL shifter, latency 1, sharing the block's reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) sh_out <= 16'h0000;
    else      sh_out <= sh_inp << sh_shift[3:0];
  end

  function automatic logic [15:0] model_result(input logic [1:0] op, input logic [15:0] x,
                                               input logic [3:0] n);
    logic [15:0] r;
    case (op)
      2'b00:   r = x << n;
      2'b01:   r = x >> n;
      2'b10:   r = 16'($signed(x) >>> n);
      default: r = (n == 0) ? x : ((x << n) | (x >> (16 - n)));
    endcase
    return r;
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [15:0] x,
                                       input logic [3:0] n);
    if (op == 2'b11 || (op == 2'b10 && x[15] && n != 0)) return 4;
    return 2;
  endfunction

  function automatic logic [2:0] model_flags(input logic [1:0] op, input logic [15:0] x,
                                             input logic [3:0] n, input logic [15:0] r);
    logic c;
    c = 1'b0;
    if (n != 0) begin
      case (op)
        2'b00:   c = x[16 - n];
        2'b01,
        2'b10:   c = x[n - 1];
        default: c = r[0];
      endcase
    end
    return {r[15], (r == 16'h0000), c};
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] shamt,
                        input int stall, input string tag);
    logic [15:0] exp;
    int exp_lat, lat, k;
    bit got, busy_bad;
    logic [3:0] n;
    n = shamt[3:0];
    exp = model_result(op, x, n);
    exp_lat = model_latency(op, x, n);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s idle_ready: in_ready=%b required 1", tag, in_ready);
    else pass_cnt++;
    in_valid = 1'b1; in_op = op; in_data = x; in_shamt = shamt;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_data = 16'($urandom); in_shamt = 16'($urandom);
    lat = 0; got = 0; busy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
      if (in_ready) busy_bad = 1;
      @(posedge clk);
      lat++;
    end
    total_cnt++;
    if (!got || lat != exp_lat)
      $display("FAIL %s latency: got=%0b clocks=%0d required %0d", tag, got, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad) $display("FAIL %s busy_ready: in_ready=1 while busy, required 0", tag);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== exp) $display("FAIL %s data: out_data=%h required %h", tag, out_data, exp);
    else pass_cnt++;
`ifdef SHIFT_SEQ_FLAGS_EN
    total_cnt++;
    if (out_flags !== model_flags(op, x, n, exp))
      $display("FAIL %s flags: out_flags=%b required %b", tag, out_flags, model_flags(op, x, n, exp));
    else pass_cnt++;
`endif
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_op = 2'($urandom); in_data = 16'($urandom); in_shamt = 16'($urandom);
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0)
        $display("FAIL %s stall: valid=%b data=%h ready=%b required 1 %h 0",
                 tag, out_valid, out_data, in_ready, exp);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s release: in_ready=%b out_valid=%b required 1 0", tag, in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_data = 16'h0000; in_shamt = 16'h0000;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000 ||
        sh_inp !== 16'h0000 || sh_shift !== 16'h0000)
      $display("FAIL reset_values: ready=%b valid=%b data=%h sh_inp=%h sh_shift=%h required 1 0 0000 0000 0000",
               in_ready, out_valid, out_data, sh_inp, sh_shift);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(2'b00, 16'h000B, 16'h0001, 0, "lsl_b_1");
    run_op(2'b01, 16'hF000, 16'h0004, 0, "lsr_f000_4");
    run_op(2'b01, 16'h8001, 16'h001F, 0, "lsr_upper_shamt");
    run_op(2'b10, 16'h8000, 16'h0004, 0, "asr_neg_4");
    run_op(2'b10, 16'h4000, 16'h0004, 0, "asr_pos_4");
    run_op(2'b10, 16'h8000, 16'h0000, 0, "asr_neg_0");
    run_op(2'b11, 16'h8001, 16'h0001, 0, "rol_8001_1");
    run_op(2'b11, 16'h1234, 16'h0000, 0, "rol_n0");
    run_op(2'b00, 16'h8000, 16'h0001, 0, "lsl_zero");
    run_op(2'b01, 16'hFFFF, 16'h000F, 0, "lsr_max");
  endtask

  task automatic test_backpressure();
    run_op(2'b11, 16'hA5C3, 16'h0005, 5, "backpressure_rol");
    run_op(2'b00, 16'h0F0F, 16'h0003, 5, "backpressure_lsl");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      run_op(2'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), "random");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [4];
    logic [15:0] xs  [4];
    logic [15:0] ns  [4];
    int idx;
    for (int i = 0; i < 4; i++) begin
      ops[i] = 2'($urandom); xs[i] = 16'($urandom); ns[i] = 16'($urandom);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = ops[0]; in_data = xs[0]; in_shamt = ns[0];
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        total_cnt++;
        if (out_data !== model_result(ops[idx], xs[idx], ns[idx][3:0]))
          $display("FAIL b2b_data[%0d]: out_data=%h required %h", idx, out_data,
                   model_result(ops[idx], xs[idx], ns[idx][3:0]));
        else pass_cnt++;
        idx++;
        if (idx < 4) begin
          in_op = ops[idx]; in_data = xs[idx]; in_shamt = ns[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (idx != 4) $display("FAIL b2b_count: results=%0d required 4", idx);
    else pass_cnt++;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b10; in_data = 16'h8000; in_shamt = 16'h0004;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sh_inp !== 16'h0000 || out_data !== 16'h0000)
      $display("FAIL reset_mid_op: valid=%b ready=%b sh_inp=%h data=%h required 0 1 0000 0000",
               out_valid, in_ready, sh_inp, out_data);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    run_op(2'b00, 16'h0001, 16'h0002, 0, "after_reset_lsl");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
